// File: rtl/ps2mouse_to_kmouse_wheel_pkg.sv
// Shared definitions for the PS/2 mouse to Kempston mouse translator:
// packet FSM states, PS/2 header layout and Kempston button bit positions.
package ps2mouse_to_kmouse_wheel_pkg;

    typedef enum logic [1:0] {
        StB0 = 2'd0,
        StB1 = 2'd1,
        StB2 = 2'd2,
        StB3 = 2'd3
    } pkt_state_e;

    // PS/2 byte 0 without the always-one sync bit (bit 3)
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic mid;
        logic right;
        logic left;
    } ps2_hdr_t;

    localparam int unsigned KM_RIGHT     = 0;
    localparam int unsigned KM_LEFT      = 1;
    localparam int unsigned KM_MID       = 2;
    localparam int unsigned KM_ONE       = 3;
    localparam int unsigned KM_WHEEL_LSB = 4;
    localparam int unsigned KM_WHEEL_MSB = 7;

    localparam logic [7:0] KM_BTN_RST = 8'h0F;

endpackage

// File: rtl/ps2mouse_to_kmouse_wheel_kmouse_axis_acc.sv
// One Kempston axis: scales a 9-bit signed PS/2 delta and adds it into a
// wrapping 8-bit position counter on commit unless the axis overflowed.
module kmouse_axis_acc #(
    parameter int unsigned SCALE_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] delta,
    input  logic       ovf,
    input  logic       commit,
    output logic [7:0] acc
);

    logic signed [8:0] scaled;
    logic        [7:0] acc_q;

    // Arithmetic shift floors toward -inf, so -1 stays -1 at any scale
    assign scaled = $signed(delta) >>> SCALE_SHIFT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else if (commit && !ovf) begin
            acc_q <= 8'(acc_q + scaled);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ps2mouse_to_kmouse_wheel.sv
// PS/2 mouse packet assembler feeding Kempston X/Y/button ports, with an
// optional IntelliMouse wheel nibble, bit-3 resync and inter-byte timeout.
module ps2mouse_to_kmouse_wheel
    import ps2mouse_to_kmouse_wheel_pkg::*;
#(
    parameter bit          WHEEL_EN       = 1'b1,
    parameter int unsigned SCALE_SHIFT    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TMO_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    input  logic       intellimouse,
    output logic [7:0] kmouse_x,
    output logic [7:0] kmouse_y,
    output logic [7:0] kmouse_buttons,
    output logic       packet_done,
    output logic       sync_err
);

    pkt_state_e       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    ps2_hdr_t         hdr_q;
    logic [7:0]       dx_q, dy_q, dy_cur;
    logic             mode4_q;
    logic [3:0]       wheel_q;
    logic [2:0]       btn_q;
    logic             packet_done_q, sync_err_q;

    logic hold_hdr, hold_dx, hold_dy, commit, bad_hdr, timeout;

    assign timeout = (state_q != StB0) && !data_valid
                     && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StB0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StB0;
        end else if (data_valid) begin
            unique case (state_q)
                StB0:    state_d = data[3] ? StB1 : StB0;
                StB1:    state_d = StB2;
                StB2:    state_d = mode4_q ? StB3 : StB0;
                StB3:    state_d = StB0;
                default: state_d = StB0;
            endcase
        end
        tmo_d = (state_q == StB0 || data_valid || timeout) ? '0 : tmo_q + 1'b1;
    end

    always_comb begin
        hold_hdr = 1'b0;
        hold_dx  = 1'b0;
        hold_dy  = 1'b0;
        commit   = 1'b0;
        bad_hdr  = 1'b0;
        if (data_valid) begin
            unique case (state_q)
                StB0: begin
                    hold_hdr = data[3];
                    bad_hdr  = ~data[3];
                end
                StB1:    hold_dx = 1'b1;
                StB2: begin
                    hold_dy = 1'b1;
                    commit  = ~mode4_q;
                end
                StB3:    commit = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q         <= '0;
            dx_q          <= 8'h00;
            dy_q          <= 8'h00;
            mode4_q       <= 1'b0;
            wheel_q       <= 4'h0;
            btn_q         <= KM_BTN_RST[2:0];
            packet_done_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            if (hold_hdr) begin
                hdr_q   <= '{y_ovf: data[7], x_ovf: data[6], y_sign: data[5],
                             x_sign: data[4], mid: data[2], right: data[1], left: data[0]};
                mode4_q <= intellimouse & WHEEL_EN;
            end
            if (hold_dx) dx_q <= data;
            if (hold_dy) dy_q <= data;
            if (commit) begin
                btn_q <= {~hdr_q.mid, ~hdr_q.left, ~hdr_q.right};
                // In a 4-byte packet the committing byte is dz
                if (mode4_q) wheel_q <= wheel_q + data[3:0];
            end
            packet_done_q <= commit;
            sync_err_q    <= bad_hdr | timeout;
        end
    end

    // The committing byte of a 3-byte packet is dy itself
    assign dy_cur = hold_dy ? data : dy_q;

    kmouse_axis_acc #(
        .SCALE_SHIFT(SCALE_SHIFT)
    ) u_acc_x (
        .clk   (clk),
        .rst   (rst),
        .delta ({hdr_q.x_sign, dx_q}),
        .ovf   (hdr_q.x_ovf),
        .commit(commit),
        .acc   (kmouse_x)
    );

    kmouse_axis_acc #(
        .SCALE_SHIFT(SCALE_SHIFT)
    ) u_acc_y (
        .clk   (clk),
        .rst   (rst),
        .delta ({hdr_q.y_sign, dy_cur}),
        .ovf   (hdr_q.y_ovf),
        .commit(commit),
        .acc   (kmouse_y)
    );

    always_comb begin
        kmouse_buttons                             = KM_BTN_RST;
        kmouse_buttons[KM_WHEEL_MSB:KM_WHEEL_LSB]  = wheel_q;
        kmouse_buttons[KM_ONE]                     = 1'b1;
        kmouse_buttons[KM_MID]                     = btn_q[2];
        kmouse_buttons[KM_LEFT]                    = btn_q[1];
        kmouse_buttons[KM_RIGHT]                   = btn_q[0];
    end

    assign packet_done = packet_done_q;
    assign sync_err    = sync_err_q;

endmodule
